demux_2x1_dispatcher: RTL and testbench
=======================================

DEMUX_2X1_DISPATCHER -- requirements
Module: demux_2x1_dispatcher

Interface
REQ-001 SHALL have parameter N, default 4, giving the data word width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: dispatch enable; low stops new acceptances.
REQ-005 SHALL have port mode, input, 1 bit: 0 = round-robin routing, 1 = steered routing by s.
REQ-006 SHALL have port s, input, 1 bit: output select in steered mode (0 -> w0, 1 -> w1).
REQ-007 SHALL have port f, input, N bits: input data word.
REQ-008 SHALL have port f_valid, input, 1 bit: input word present.
REQ-009 SHALL have port f_ready, output, 1 bit: the block accepts f this cycle.
REQ-010 SHALL have ports w0 and w1, output, N bits each: registered output data.
REQ-011 SHALL have ports w0_valid and w1_valid, output, 1 bit each: the output slot holds a word.
REQ-012 SHALL have ports w0_ready and w1_ready, input, 1 bit each: the downstream consumer takes the word.
REQ-013 SHALL have ports cnt0 and cnt1, output, 8 bits each: words delivered on w0 and w1.
REQ-014 SHALL have port busy, output, 1 bit: high in state RUN or DRAIN.

Function
REQ-015 SHALL define target = s when mode=1, otherwise the round-robin pointer ptr.
REQ-016 SHALL drive f_ready = (state==RUN) && en && (target slot empty || target slot's ready high), combinationally.
REQ-017 SHALL perform an accept when f_valid && f_ready; f then loads the target slot, whose valid is high on the next cycle (1-cycle latency).
REQ-018 SHALL perform a delivery on wX when wX_valid && wX_ready; the slot clears unless reloaded in the same cycle.
REQ-019 SHALL allow accept and delivery on the same slot in the same cycle, giving full throughput of 1 word/cycle per slot.
REQ-020 SHALL toggle ptr on every accept when mode=0, and hold ptr when mode=1.
REQ-021 SHALL hold wX data stable while wX_valid is high and wX_ready is low.
REQ-022 SHALL never route a word to both outputs, and the non-target slot SHALL be unaffected by an accept.
REQ-023 SHALL increment cntX by 1 per delivery on wX, wrapping from 255 to 0.
REQ-024 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-025 SHALL move IDLE->RUN when en=1.
REQ-026 SHALL move RUN->DRAIN when en=0 and any slot is valid, and RUN->IDLE when en=0 and both slots are empty.
REQ-027 SHALL move DRAIN->IDLE once both slots are empty; en rising during DRAIN SHALL return to RUN.
REQ-028 SHALL keep f_ready low in IDLE and DRAIN.
REQ-029 SHALL take effect on the next accept when mode or s changes mid-stream; words already held are not moved.

Reset
REQ-030 SHALL, on reset_n low, immediately clear state=IDLE, ptr=0, w0_valid=w1_valid=0, w0=w1=0, cnt0=cnt1=0 and busy=0.
REQ-031 SHALL discard words held in a slot when reset is asserted mid-operation; there is no recovery.
REQ-032 SHALL leave IDLE no earlier than the first rising clk edge after reset_n deasserts.

Structure
REQ-033 SHALL place the state encodings (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) and the default width N=4 in the shared package demux_pkg.
REQ-034 SHALL implement each output slot (data register, valid flag, load/drain logic) as sub-module demux_out_slot, instantiated twice.

Verification
REQ-035 SHALL verify round-robin: en=1, mode=0, both ready=1, f=3,5,7,9 on consecutive cycles -> w0 gets 3,7 and w1 gets 5,9, each 1 cycle after accept, and cnt0=cnt1=2.
REQ-036 SHALL verify steering: mode=1, s=1, f=3 then s=0, f=3 -> first word on w1 only, second on w0 only, and ptr unchanged.
REQ-037 SHALL verify backpressure: mode=1, s=0, w0_ready=0, f=4 then f=6 offered -> w0 holds 4, f_ready=0 while 6 is offered; w0_ready=1 -> 4 delivers and 6 is accepted in the same cycle.
REQ-038 SHALL verify drain: w1 holds a word with w1_ready=0, en dropped -> state DRAIN, f_ready=0, busy=1; w1_ready=1 -> delivery, then IDLE and busy=0.
REQ-039 SHALL verify counter wrap: 256 deliveries on w0 -> cnt0 returns to 0.
REQ-040 SHALL verify asynchronous reset: reset_n pulsed low between clk edges with both slots full -> all outputs 0 immediately, and after release f_ready stays 0 until en=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 2-way demux dispatcher: FSM encoding and default width.
package demux_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One registered output slot: holds a word until the consumer takes it.
// A load and a delivery may coincide, which gives one word per cycle per slot.
module demux_out_slot #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [N-1:0] din,
   input  logic         ready,
   output logic [N-1:0] data,
   output logic         valid,
   output logic         delivered
);

   assign delivered = valid && ready;

   // Load wins over clear, so back-to-back words never leave a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= din;
         valid <= 1'b1;
      end else if (delivered) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_2x1_dispatcher.sv
// Two-output dispatcher: routes each accepted input word to w0 or w1, either
// alternating (round-robin) or steered by s, and counts deliveries per output.
//
// state | meaning
// IDLE  | not accepting, no words held
// RUN   | accepting words while en is high
// DRAIN | en dropped, waiting for held words to be taken
module demux_2x1_dispatcher
   import demux_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         mode,
   input  logic         s,
   input  logic [N-1:0] f,
   input  logic         f_valid,
   output logic         f_ready,
   output logic [N-1:0] w0,
   output logic [N-1:0] w1,
   output logic         w0_valid,
   output logic         w1_valid,
   input  logic         w0_ready,
   input  logic         w1_ready,
   output logic [7:0]   cnt0,
   output logic [7:0]   cnt1,
   output logic         busy
);

   state_t state, state_nxt;
   logic   ptr;
   logic   target;
   logic   target_free;
   logic   accept;
   logic   del0, del1;

   assign target      = mode ? s : ptr;
   assign target_free = target ? (!w1_valid || w1_ready) : (!w0_valid || w0_ready);
   assign f_ready     = (state == RUN) && en && target_free;
   assign accept      = f_valid && f_ready;
   assign busy        = (state == RUN) || (state == DRAIN);

   demux_out_slot #(.N(N)) u_slot0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept && !target),
      .din       (f),
      .ready     (w0_ready),
      .data      (w0),
      .valid     (w0_valid),
      .delivered (del0)
   );

   demux_out_slot #(.N(N)) u_slot1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept && target),
      .din       (f),
      .ready     (w1_ready),
      .data      (w1),
      .valid     (w1_valid),
      .delivered (del1)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; DRAIN waits on the registered valids of both slots.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = (w0_valid || w1_valid) ? DRAIN : IDLE;
         DRAIN: begin
            if (en)                          state_nxt = RUN;
            else if (!w0_valid && !w1_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Round-robin pointer advances only on accepts made in round-robin mode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)             ptr <= 1'b0;
      else if (accept && !mode) ptr <= ~ptr;
   end

   // Delivery counters, free-running modulo 256.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt0 <= 8'd0;
         cnt1 <= 8'd0;
      end else begin
         if (del0) cnt0 <= cnt0 + 8'd1;
         if (del1) cnt1 <= cnt1 + 8'd1;
      end
   end

endmodule

// File: tb/tb_demux_2x1_dispatcher.sv
// Directed bench for demux_2x1_dispatcher.
module tb_demux_2x1_dispatcher;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         en, mode, s, f_valid, w0_ready, w1_ready;
   logic [N-1:0] f;
   logic         f_ready, w0_valid, w1_valid, busy;
   logic [N-1:0] w0, w1;
   logic [7:0]   cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   demux_2x1_dispatcher #(.N(N)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .mode     (mode),
      .s        (s),
      .f        (f),
      .f_valid  (f_valid),
      .f_ready  (f_ready),
      .w0       (w0),
      .w1       (w1),
      .w0_valid (w0_valid),
      .w1_valid (w1_valid),
      .w0_ready (w0_ready),
      .w1_ready (w1_ready),
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; en = 0; mode = 0; s = 0; f = '0; f_valid = 0;
      w0_ready = 0; w1_ready = 0;
      #2;
      chk("rst_w0v", 32'(w0_valid), 0);
      chk("rst_w1v", 32'(w1_valid), 0);
      chk("rst_w0", 32'(w0), 0);
      chk("rst_w1", 32'(w1), 0);
      chk("rst_cnt0", 32'(cnt0), 0);
      chk("rst_cnt1", 32'(cnt1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fready", 32'(f_ready), 0);
      #10 reset_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 0);

      // round robin: 3,5,7,9 -> w0 gets 3,7 ; w1 gets 5,9
      en = 1; w0_ready = 1; w1_ready = 1;
      tick();
      chk("rr_busy", 32'(busy), 1);
      f = 3; f_valid = 1; #1;
      chk("rr_fready", 32'(f_ready), 1);
      tick();
      chk("rr_w0v_a", 32'(w0_valid), 1);
      chk("rr_w0_a", 32'(w0), 3);
      chk("rr_w1v_a", 32'(w1_valid), 0);
      f = 5; tick();
      chk("rr_w1_b", 32'(w1), 5);
      chk("rr_w1v_b", 32'(w1_valid), 1);
      chk("rr_w0v_b", 32'(w0_valid), 0);
      chk("rr_cnt0_b", 32'(cnt0), 1);
      f = 7; tick();
      chk("rr_w0_c", 32'(w0), 7);
      chk("rr_w0v_c", 32'(w0_valid), 1);
      chk("rr_w1v_c", 32'(w1_valid), 0);
      chk("rr_cnt1_c", 32'(cnt1), 1);
      f = 9; tick();
      chk("rr_w1_d", 32'(w1), 9);
      chk("rr_w0v_d", 32'(w0_valid), 0);
      chk("rr_cnt0_d", 32'(cnt0), 2);
      f_valid = 0; tick();
      chk("rr_cnt0", 32'(cnt0), 2);
      chk("rr_cnt1", 32'(cnt1), 2);
      chk("rr_w1v_e", 32'(w1_valid), 0);

      // steering: s=1 -> w1 only, s=0 -> w0 only
      mode = 1; s = 1; f = 3; f_valid = 1; tick();
      chk("st_w1v", 32'(w1_valid), 1);
      chk("st_w1", 32'(w1), 3);
      chk("st_w0v", 32'(w0_valid), 0);
      s = 0; tick();
      chk("st_w0v2", 32'(w0_valid), 1);
      chk("st_w0_2", 32'(w0), 3);
      chk("st_w1v2", 32'(w1_valid), 0);
      chk("st_cnt1", 32'(cnt1), 3);
      f_valid = 0; tick();
      chk("st_cnt0", 32'(cnt0), 3);
      // pointer was left at 0 by round-robin; steering must not have moved it
      mode = 0; f = 8; f_valid = 1; tick();
      chk("st_ptr_w0v", 32'(w0_valid), 1);
      chk("st_ptr_w0", 32'(w0), 8);
      chk("st_ptr_w1v", 32'(w1_valid), 0);
      f_valid = 0; tick();
      chk("st_cnt0b", 32'(cnt0), 4);

      // backpressure on w0
      mode = 1; s = 0; w0_ready = 0; f = 4; f_valid = 1; #1;
      chk("bp_fready1", 32'(f_ready), 1);
      tick();
      chk("bp_w0", 32'(w0), 4);
      f = 6; #1;
      chk("bp_fready0", 32'(f_ready), 0);
      tick();
      chk("bp_hold_w0", 32'(w0), 4);
      chk("bp_hold_v", 32'(w0_valid), 1);
      chk("bp_hold_cnt", 32'(cnt0), 4);
      w0_ready = 1; #1;
      chk("bp_fready2", 32'(f_ready), 1);
      tick();
      chk("bp_w0_6", 32'(w0), 6);
      chk("bp_w0v_6", 32'(w0_valid), 1);
      chk("bp_cnt0", 32'(cnt0), 5);
      f_valid = 0; tick();
      chk("bp_cnt0b", 32'(cnt0), 6);
      chk("bp_w0v_e", 32'(w0_valid), 0);

      // drain with word stuck in w1
      s = 1; w1_ready = 0; f = 10; f_valid = 1; tick();
      chk("dr_w1v", 32'(w1_valid), 1);
      f_valid = 0; en = 0; #1;
      chk("dr_fready_a", 32'(f_ready), 0);
      tick();
      chk("dr_busy", 32'(busy), 1);
      chk("dr_fready", 32'(f_ready), 0);
      tick();
      chk("dr_busy2", 32'(busy), 1);
      chk("dr_w1_hold", 32'(w1), 10);
      w1_ready = 1; tick();
      chk("dr_w1v0", 32'(w1_valid), 0);
      chk("dr_cnt1", 32'(cnt1), 4);
      tick();
      chk("dr_idle_busy", 32'(busy), 0);

      // asynchronous reset with both slots full
      en = 1; w0_ready = 0; w1_ready = 0; tick();
      s = 0; f = 1; f_valid = 1; tick();
      s = 1; f = 2; tick();
      f_valid = 0;
      chk("ar_full0", 32'(w0_valid), 1);
      chk("ar_full1", 32'(w1_valid), 1);
      #3 reset_n = 1'b0;
      #1;
      chk("ar_w0v", 32'(w0_valid), 0);
      chk("ar_w1v", 32'(w1_valid), 0);
      chk("ar_w0", 32'(w0), 0);
      chk("ar_w1", 32'(w1), 0);
      chk("ar_cnt0", 32'(cnt0), 0);
      chk("ar_cnt1", 32'(cnt1), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_fready", 32'(f_ready), 0);
      en = 0;
      #2 reset_n = 1'b1;
      f_valid = 1; f = 5; s = 0;
      tick();
      chk("ar_post_fready", 32'(f_ready), 0);
      chk("ar_post_busy", 32'(busy), 0);
      tick();
      chk("ar_post_fready2", 32'(f_ready), 0);
      chk("ar_post_w0v", 32'(w0_valid), 0);
      en = 1; w0_ready = 1; w1_ready = 1; #1;
      chk("ar_idle_fready", 32'(f_ready), 0);
      tick();
      chk("ar_run_fready", 32'(f_ready), 1);
      chk("ar_run_busy", 32'(busy), 1);

      // counter wrap on w0 (f_valid still high, s=0, mode=1)
      for (int i = 0; i < 255; i++) tick();
      f_valid = 0; tick();
      chk("wr_cnt0_255", 32'(cnt0), 255);
      f_valid = 1; tick();
      f_valid = 0; tick();
      chk("wr_cnt0_0", 32'(cnt0), 0);
      chk("wr_cnt1", 32'(cnt1), 0);

      // en rising during DRAIN returns to RUN
      s = 1; w1_ready = 0; f = 12; f_valid = 1; tick();
      f_valid = 0; en = 0; tick();
      chk("dr2_busy", 32'(busy), 1);
      en = 1; s = 0; tick();
      chk("dr2_run_fready", 32'(f_ready), 1);
      chk("dr2_w1_hold", 32'(w1), 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
